// File: rtl/eth_rx_tx_buf_ctrl_if.sv
// Bus bundle between eth_rx_tx_buf_ctrl and its surroundings.
// slave  : the buffer controller (consumes RX stream, produces TX stream, masters s2).
// master : the environment (MAC FIFO side, Nios control, rx_tx_buf s2 port).
// Groups: RX Avalon-ST sink + RX status, TX command/status + Avalon-ST source, s2 port.
interface eth_rx_tx_buf_ctrl_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned CNT_W  = 16
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_sop;
  logic              rx_eop;
  logic              rx_ready;
  logic [ADDR_W-1:0] rx_len;
  logic              rx_pending;
  logic              rx_release;
  logic              rx_err;
  logic [CNT_W-1:0]  rx_drop_cnt;
  logic              irq;

  logic              tx_start;
  logic [ADDR_W-1:0] tx_len;
  logic              tx_busy;
  logic              tx_done;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_sop;
  logic              tx_eop;
  logic              tx_ready;

  logic [ADDR_W-1:0] buf_address;
  logic              buf_chipselect;
  logic              buf_write;
  logic              buf_clken;
  logic [7:0]        buf_writedata;
  logic [7:0]        buf_readdata;

  modport slave (
    input  rx_data, rx_valid, rx_sop, rx_eop, rx_release,
    input  tx_start, tx_len, tx_ready, buf_readdata,
    output rx_ready, rx_len, rx_pending, rx_err, rx_drop_cnt, irq,
    output tx_busy, tx_done, tx_data, tx_valid, tx_sop, tx_eop,
    output buf_address, buf_chipselect, buf_write, buf_clken, buf_writedata
  );

  modport master (
    output rx_data, rx_valid, rx_sop, rx_eop, rx_release,
    output tx_start, tx_len, tx_ready, buf_readdata,
    input  rx_ready, rx_len, rx_pending, rx_err, rx_drop_cnt, irq,
    input  tx_busy, tx_done, tx_data, tx_valid, tx_sop, tx_eop,
    input  buf_address, buf_chipselect, buf_write, buf_clken, buf_writedata
  );
endinterface

// File: rtl/eth_rx_tx_buf_ctrl.sv
// Shares the rx_tx_buf s2 port between an RX frame writer (MAC stream -> RX region,
// irq while a frame is held) and a TX frame reader (TX region -> MAC stream).
// Ports: clk, reset (async, active-high), bus (eth_rx_tx_buf_ctrl_if.slave) carrying
// the RX sink/status, TX command/source and s2 address/strobe/data signals.
module eth_rx_tx_buf_ctrl #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned RX_BASE = 0,
  parameter int unsigned RX_SIZE = 1024,
  parameter int unsigned TX_BASE = 1024,
  parameter int unsigned TX_SIZE = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input logic                  clk,
  input logic                  reset,
  eth_rx_tx_buf_ctrl_if.slave  bus
);
  localparam int unsigned CW = ADDR_W + 1;
  localparam logic [CW-1:0]     RX_SIZE_C = CW'(RX_SIZE);
  localparam logic [CW-1:0]     TX_SIZE_C = CW'(TX_SIZE);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_FRAME = 2'd1;
  localparam logic [1:0] RX_HOLD  = 2'd2;
  localparam logic [1:0] RX_DROP  = 2'd3;
  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_RUN   = 2'd1;
  localparam logic [1:0] TX_DRAIN = 2'd2;

  // RX side
  logic [1:0]        rx_state, rx_state_n;
  logic [CW-1:0]     wr_cnt, wr_cnt_n;
  logic              in_frame, in_frame_n;
  logic              pending, pending_n;
  logic [ADDR_W-1:0] rx_len_q, rx_len_n;
  logic              err_n, err_q, drop_inc;
  logic [CNT_W-1:0]  drop_cnt;
  logic              rdy_q, clken_q, beat;
  logic              wr_n;
  logic [ADDR_W-1:0] wr_addr_n;

  // TX side
  logic [1:0]        tx_state, tx_state_n;
  logic [ADDR_W-1:0] tx_len_q, tx_len_n, rd_ptr, rd_ptr_n, head_idx, head_idx_n;
  logic [7:0]        ent0, ent0_n, ent1, ent1_n;
  logic              v0, v0_n, v1, v1_n;
  logic              rd_n, rd_issue_q, rd_lat_q, pop, credit_ok, done_n;
  logic              sop_q, eop_q, busy_q, done_q;
  logic [ADDR_W-1:0] rd_addr_n;
  logic [2:0]        used;

  // s2 port registers
  logic [ADDR_W-1:0] buf_addr_q;
  logic              buf_cs_q, buf_we_q;
  logic [7:0]        buf_wd_q;

  assign beat = bus.rx_valid & rdy_q;
  assign pop  = v0 & bus.tx_ready;

  // RX next-state: frame capture, oversize/abort handling, hold until released
  always_comb begin
    rx_state_n = rx_state;
    wr_cnt_n   = wr_cnt;
    in_frame_n = in_frame;
    pending_n  = pending;
    rx_len_n   = rx_len_q;
    err_n      = 1'b0;
    drop_inc   = 1'b0;
    wr_n       = 1'b0;
    wr_addr_n  = ADDR_W'(RX_BASE);
    case (rx_state)
      RX_IDLE: begin
        if (beat && bus.rx_sop) begin
          wr_n     = 1'b1;
          wr_cnt_n = CW'(1);
          if (bus.rx_eop) begin
            pending_n  = 1'b1;
            rx_len_n   = ONE_A;
            in_frame_n = 1'b0;
            rx_state_n = RX_HOLD;
          end else begin
            rx_state_n = RX_FRAME;
          end
        end
      end
      RX_FRAME: begin
        if (beat) begin
          if (bus.rx_sop) begin
            // new sop aborts the partial frame and restarts at the region base
            err_n    = 1'b1;
            drop_inc = 1'b1;
            wr_n     = 1'b1;
            wr_cnt_n = CW'(1);
            if (bus.rx_eop) begin
              pending_n  = 1'b1;
              rx_len_n   = ONE_A;
              in_frame_n = 1'b0;
              rx_state_n = RX_HOLD;
            end
          end else if (wr_cnt == RX_SIZE_C) begin
            // region full: this byte would overflow, so the frame is discarded
            err_n      = 1'b1;
            drop_inc   = 1'b1;
            rx_state_n = bus.rx_eop ? RX_IDLE : RX_DROP;
          end else begin
            wr_n      = 1'b1;
            wr_addr_n = ADDR_W'(RX_BASE + 32'(wr_cnt));
            wr_cnt_n  = wr_cnt + CW'(1);
            if (bus.rx_eop) begin
              pending_n  = 1'b1;
              rx_len_n   = ADDR_W'(wr_cnt + CW'(1));
              in_frame_n = 1'b0;
              rx_state_n = RX_HOLD;
            end
          end
        end
      end
      RX_HOLD: begin
        if (beat) begin
          if (bus.rx_sop) begin
            drop_inc   = 1'b1;
            in_frame_n = ~bus.rx_eop;
          end else if (bus.rx_eop) begin
            in_frame_n = 1'b0;
          end
        end
        if (bus.rx_release) begin
          pending_n  = 1'b0;
          rx_state_n = in_frame_n ? RX_DROP : RX_IDLE;
        end
      end
      RX_DROP: begin
        if (beat && bus.rx_eop) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // TX next-state: read scheduling with credit check, 2-entry output FIFO
  always_comb begin
    tx_state_n = tx_state;
    tx_len_n   = tx_len_q;
    rd_ptr_n   = rd_ptr;
    head_idx_n = head_idx;
    rd_n       = 1'b0;
    rd_addr_n  = ADDR_W'(TX_BASE);
    done_n     = 1'b0;
    ent0_n     = ent0;
    ent1_n     = ent1;
    v0_n       = v0;
    v1_n       = v1;
    // pops are not credited back early; keeps the FIFO bound simple
    used       = 3'(v0) + 3'(v1) + 3'(rd_issue_q) + 3'(rd_lat_q);
    credit_ok  = used < 3'd2;

    if (pop) begin
      ent0_n     = ent1;
      v0_n       = v1;
      v1_n       = 1'b0;
      head_idx_n = head_idx + ONE_A;
    end
    if (rd_lat_q) begin
      if (!v0_n) begin
        ent0_n = bus.buf_readdata;
        v0_n   = 1'b1;
      end else begin
        ent1_n = bus.buf_readdata;
        v1_n   = 1'b1;
      end
    end

    case (tx_state)
      TX_IDLE: begin
        if (bus.tx_start && (bus.tx_len != '0) && (CW'(bus.tx_len) <= TX_SIZE_C)) begin
          tx_len_n   = bus.tx_len;
          rd_ptr_n   = '0;
          head_idx_n = '0;
          tx_state_n = TX_RUN;
        end
      end
      TX_RUN: begin
        // RX write owns s2 in any cycle it needs it
        if (!wr_n && credit_ok) begin
          rd_n      = 1'b1;
          rd_addr_n = ADDR_W'(TX_BASE + 32'(rd_ptr));
          rd_ptr_n  = rd_ptr + ONE_A;
          if (rd_ptr == tx_len_q - ONE_A) tx_state_n = TX_DRAIN;
        end
      end
      TX_DRAIN: begin
        if (pop && (head_idx == tx_len_q - ONE_A)) begin
          done_n     = 1'b1;
          tx_state_n = TX_IDLE;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      wr_cnt     <= '0;
      in_frame   <= 1'b0;
      pending    <= 1'b0;
      rx_len_q   <= '0;
      err_q      <= 1'b0;
      drop_cnt   <= '0;
      rdy_q      <= 1'b0;
      clken_q    <= 1'b0;
      tx_state   <= TX_IDLE;
      tx_len_q   <= '0;
      rd_ptr     <= '0;
      head_idx   <= '0;
      ent0       <= '0;
      ent1       <= '0;
      v0         <= 1'b0;
      v1         <= 1'b0;
      rd_issue_q <= 1'b0;
      rd_lat_q   <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      buf_addr_q <= '0;
      buf_cs_q   <= 1'b0;
      buf_we_q   <= 1'b0;
      buf_wd_q   <= '0;
    end else begin
      rx_state   <= rx_state_n;
      wr_cnt     <= wr_cnt_n;
      in_frame   <= in_frame_n;
      pending    <= pending_n;
      rx_len_q   <= rx_len_n;
      err_q      <= err_n;
      if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
      rdy_q      <= 1'b1;
      clken_q    <= 1'b1;
      tx_state   <= tx_state_n;
      tx_len_q   <= tx_len_n;
      rd_ptr     <= rd_ptr_n;
      head_idx   <= head_idx_n;
      ent0       <= ent0_n;
      ent1       <= ent1_n;
      v0         <= v0_n;
      v1         <= v1_n;
      rd_issue_q <= rd_n;
      rd_lat_q   <= rd_issue_q;
      sop_q      <= v0_n && (head_idx_n == '0);
      eop_q      <= v0_n && (head_idx_n == tx_len_n - ONE_A);
      busy_q     <= tx_state_n != TX_IDLE;
      done_q     <= done_n;
      if (wr_n) begin
        buf_addr_q <= wr_addr_n;
        buf_cs_q   <= 1'b1;
        buf_we_q   <= 1'b1;
        buf_wd_q   <= bus.rx_data;
      end else if (rd_n) begin
        buf_addr_q <= rd_addr_n;
        buf_cs_q   <= 1'b1;
        buf_we_q   <= 1'b0;
      end else begin
        buf_cs_q   <= 1'b0;
        buf_we_q   <= 1'b0;
      end
    end
  end

  assign bus.rx_ready       = rdy_q;
  assign bus.rx_len         = rx_len_q;
  assign bus.rx_pending     = pending;
  assign bus.rx_err         = err_q;
  assign bus.rx_drop_cnt    = drop_cnt;
  assign bus.irq            = pending;
  assign bus.tx_busy        = busy_q;
  assign bus.tx_done        = done_q;
  assign bus.tx_data        = ent0;
  assign bus.tx_valid       = v0;
  assign bus.tx_sop         = sop_q;
  assign bus.tx_eop         = eop_q;
  assign bus.buf_address    = buf_addr_q;
  assign bus.buf_chipselect = buf_cs_q;
  assign bus.buf_write      = buf_we_q;
  assign bus.buf_clken      = clken_q;
  assign bus.buf_writedata  = buf_wd_q;
endmodule
